// File: rtl/nonce_encoder.sv
// Collapses the per-core hit vector into success + nonce_prefix with a registered, 1-cycle path, and tracks
// suffix exhaustion and lost hits. Optional stop-after-first-hit mode: NONCE_ENCODER_STOP_ON_FIRST_EN.
module nonce_encoder #(
  parameter int PARTITIONBITS = 4,
  parameter int DROPBITS      = 8,
  parameter int SUFFIXBITS    = 32 - PARTITIONBITS,
  localparam int NPROC        = 2 ** PARTITIONBITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic                     newblock_i,
  input  logic [NPROC-1:0]         hit_i,
  output logic                     valid_o,
  output logic                     newblock_o,
  output logic                     success_o,
  output logic [PARTITIONBITS-1:0] nonce_prefix_o,
  output logic                     multi_hit_o,
  output logic [DROPBITS-1:0]      dropped_o,
  output logic                     exhausted_o,
  output logic [1:0]               dbg_state
);

  localparam int CNTW = PARTITIONBITS + 1;
  localparam int SUMW = DROPBITS + CNTW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SUFFIXBITS-1:0]    suffix_q, suffix_d;
  logic [CNTW-1:0]          hit_count;
  logic [PARTITIONBITS-1:0] first_idx;
  logic                     found;
  logic                     start, step, accept;
  logic                     success_d, multi_d, exhausted_d;
  logic [PARTITIONBITS-1:0] prefix_d;
  logic [DROPBITS-1:0]      dropped_base, dropped_d;
  logic [CNTW-1:0]          drop_add;
  logic [SUMW-1:0]          drop_sum;

  assign dbg_state = state_q;

  // Popcount and lowest-index priority encode of the hit vector.
  always_comb begin
    hit_count = '0;
    first_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NPROC; k++) begin
      if (hit_i[k]) begin
        hit_count = hit_count + CNTW'(1);
        if (!found) begin
          first_idx = PARTITIONBITS'(k);
          found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    start        = valid_i & newblock_i;
    step         = valid_i & ~newblock_i & (state_q != IDLE);
    accept       = start | (valid_i & ~newblock_i & (state_q == SEARCH));
    state_d      = state_q;
    suffix_d     = suffix_q;
    exhausted_d  = exhausted_o;
    dropped_base = dropped_o;
    drop_add     = '0;
    success_d    = 1'b0;
    prefix_d     = '0;
    multi_d      = 1'b0;

    // A newblock always restarts the search, even on the cycle the suffix would wrap.
    if (start) begin
      state_d      = SEARCH;
      suffix_d     = SUFFIXBITS'(1);
      exhausted_d  = 1'b0;
      dropped_base = '0;
    end else if (step) begin
      suffix_d = suffix_q + SUFFIXBITS'(1);
      if (&suffix_q) begin
        exhausted_d = 1'b1;
        state_d     = DONE;
      end
    end

    if (accept) begin
      success_d = found;
      prefix_d  = first_idx;
      multi_d   = (hit_count > CNTW'(1));
      if (multi_d) drop_add = hit_count - CNTW'(1);
`ifdef NONCE_ENCODER_STOP_ON_FIRST_EN
      if (found) state_d = DONE;
`endif
    end

`ifdef NONCE_ENCODER_STOP_ON_FIRST_EN
    // Once the block's result is taken, every further hit is lost.
    if (step && (state_q == DONE)) drop_add = hit_count;
`endif

    drop_sum  = SUMW'(dropped_base) + SUMW'(drop_add);
    dropped_d = (drop_sum > SUMW'({DROPBITS{1'b1}})) ? {DROPBITS{1'b1}} : drop_sum[DROPBITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      suffix_q       <= '0;
      valid_o        <= 1'b0;
      newblock_o     <= 1'b0;
      success_o      <= 1'b0;
      nonce_prefix_o <= '0;
      multi_hit_o    <= 1'b0;
      dropped_o      <= '0;
      exhausted_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      suffix_q       <= suffix_d;
      valid_o        <= valid_i;
      newblock_o     <= start;
      success_o      <= success_d;
      nonce_prefix_o <= prefix_d;
      multi_hit_o    <= multi_d;
      dropped_o      <= dropped_d;
      exhausted_o    <= exhausted_d;
    end
  end

endmodule

// File: tb/tb_nonce_encoder.sv
// Directed bench for nonce_encoder: a default instance plus a 4-bit-suffix instance for exhaustion scenarios.
module tb_nonce_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        newblock_i = 1'b0;
  logic [15:0] hit_i = '0;

  logic       valid_o, newblock_o, success_o, multi_hit_o, exhausted_o;
  logic [3:0] nonce_prefix_o;
  logic [7:0] dropped_o;
  logic [1:0] dbg_state;

  logic       valid_x, newblock_x, success_x, multi_x, exhausted_x;
  logic [3:0] prefix_x;
  logic [7:0] dropped_x;
  logic [1:0] state_x;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulses;

  always #5 clk = ~clk;

  nonce_encoder dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i), .hit_i(hit_i),
    .valid_o(valid_o), .newblock_o(newblock_o), .success_o(success_o), .nonce_prefix_o(nonce_prefix_o),
    .multi_hit_o(multi_hit_o), .dropped_o(dropped_o), .exhausted_o(exhausted_o), .dbg_state(dbg_state)
  );

  nonce_encoder #(.PARTITIONBITS(4), .DROPBITS(8), .SUFFIXBITS(4)) dut_x (
    .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i), .hit_i(hit_i),
    .valid_o(valid_x), .newblock_o(newblock_x), .success_o(success_x), .nonce_prefix_o(prefix_x),
    .multi_hit_o(multi_x), .dropped_o(dropped_x), .exhausted_o(exhausted_x), .dbg_state(state_x)
  );

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge that captured them.
  task automatic drive(input logic v, input logic nb, input logic [15:0] h);
    valid_i = v; newblock_i = nb; hit_i = h;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_i = 1'b1; newblock_i = 1'b1; hit_i = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({valid_o, newblock_o, success_o, nonce_prefix_o, multi_hit_o, dropped_o, exhausted_o} !== 17'd0)
      $display("FAIL reset_outputs: got v%0b nb%0b s%0b p%0d m%0b d%0d e%0b want all 0",
               valid_o, newblock_o, success_o, nonce_prefix_o, multi_hit_o, dropped_o, exhausted_o);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
    rst = 1'b1; valid_i = 1'b0; newblock_i = 1'b0; hit_i = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_hit();
    drive(1, 1, 16'h0000);
    total_cnt++;
    if (newblock_o !== 1'b1 || valid_o !== 1'b1 || success_o !== 1'b0)
      $display("FAIL single_newblock: got nb%0b v%0b s%0b want nb1 v1 s0", newblock_o, valid_o, success_o);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 2'd1) $display("FAIL single_state: got %0d want 1", dbg_state); else pass_cnt++;
    drive(1, 0, 16'h0000);
    drive(1, 0, 16'h0000);
    drive(1, 0, 16'h0020);
    total_cnt++;
    if (success_o !== 1'b1 || nonce_prefix_o !== 4'd5 || multi_hit_o !== 1'b0 || dropped_o !== 8'd0)
      $display("FAIL single_hit: got s%0b p%0d m%0b d%0d want s1 p5 m0 d0",
               success_o, nonce_prefix_o, multi_hit_o, dropped_o);
    else pass_cnt++;
  endtask

  task automatic test_gap();
    drive(1, 1, 16'h0000);
    drive(0, 0, 16'h0001);
    total_cnt++;
    if (success_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL gap: got s%0b v%0b want s0 v0", success_o, valid_o);
    else pass_cnt++;
    drive(1, 0, 16'h0001);
    total_cnt++;
    if (success_o !== 1'b1 || nonce_prefix_o !== 4'd0 || valid_o !== 1'b1)
      $display("FAIL after_gap: got s%0b p%0d v%0b want s1 p0 v1", success_o, nonce_prefix_o, valid_o);
    else pass_cnt++;
  endtask

  task automatic test_multi_hit();
    logic [7:0] exp_127;
`ifdef NONCE_ENCODER_STOP_ON_FIRST_EN
    exp_127 = 8'd255;
`else
    exp_127 = 8'd254;
`endif
    drive(1, 1, 16'h0000);
    drive(1, 0, 16'h8006);
    total_cnt++;
    if (success_o !== 1'b1 || nonce_prefix_o !== 4'd1 || multi_hit_o !== 1'b1 || dropped_o !== 8'd2)
      $display("FAIL multi_first: got s%0b p%0d m%0b d%0d want s1 p1 m1 d2",
               success_o, nonce_prefix_o, multi_hit_o, dropped_o);
    else pass_cnt++;
    for (int i = 2; i <= 127; i++) drive(1, 0, 16'h8006);
    total_cnt++;
    if (dropped_o !== exp_127) $display("FAIL multi_127: got %0d want %0d", dropped_o, exp_127); else pass_cnt++;
    for (int i = 128; i <= 200; i++) drive(1, 0, 16'h8006);
    total_cnt++;
    if (dropped_o !== 8'd255) $display("FAIL multi_saturate: got %0d want 255", dropped_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 16'h0080);
    total_cnt++;
    if (success_o !== 1'b1 || nonce_prefix_o !== 4'd7 || dropped_o !== 8'd0)
      $display("FAIL b2b_0: got s%0b p%0d d%0d want s1 p7 d0", success_o, nonce_prefix_o, dropped_o);
    else pass_cnt++;
    drive(1, 1, 16'h0300);
    total_cnt++;
    if (success_o !== 1'b1 || nonce_prefix_o !== 4'd8 || multi_hit_o !== 1'b1 || dropped_o !== 8'd1)
      $display("FAIL b2b_1: got s%0b p%0d m%0b d%0d want s1 p8 m1 d1",
               success_o, nonce_prefix_o, multi_hit_o, dropped_o);
    else pass_cnt++;
    drive(1, 1, 16'hFFFF);
    total_cnt++;
    if (nonce_prefix_o !== 4'd0 || dropped_o !== 8'd15 || exhausted_o !== 1'b0)
      $display("FAIL b2b_2: got p%0d d%0d e%0b want p0 d15 e0", nonce_prefix_o, dropped_o, exhausted_o);
    else pass_cnt++;
  endtask

  task automatic test_exhaustion();
    logic [1:0] exp_state;
`ifdef NONCE_ENCODER_STOP_ON_FIRST_EN
    exp_state = 2'd2;
`else
    exp_state = 2'd1;
`endif
    drive(1, 1, 16'h0000);
    for (int i = 1; i <= 7; i++) drive(1, 0, 16'h0000);
    drive(0, 0, 16'h0001);
    total_cnt++;
    if (success_x !== 1'b0 || valid_x !== 1'b0)
      $display("FAIL exh_gap: got s%0b v%0b want s0 v0", success_x, valid_x);
    else pass_cnt++;
    for (int i = 8; i <= 14; i++) drive(1, 0, 16'h0000);
    total_cnt++;
    if (exhausted_x !== 1'b0 || state_x !== 2'd1)
      $display("FAIL exh_before: got e%0b st%0d want e0 st1", exhausted_x, state_x);
    else pass_cnt++;
    drive(1, 0, 16'h0004);
    total_cnt++;
    if (exhausted_x !== 1'b1 || state_x !== 2'd2 || success_x !== 1'b1 || prefix_x !== 4'd2)
      $display("FAIL exh_wrap: got e%0b st%0d s%0b p%0d want e1 st2 s1 p2", exhausted_x, state_x, success_x, prefix_x);
    else pass_cnt++;
    drive(1, 0, 16'h0008);
    total_cnt++;
    if (success_x !== 1'b0 || exhausted_x !== 1'b1)
      $display("FAIL exh_ignored: got s%0b e%0b want s0 e1", success_x, exhausted_x);
    else pass_cnt++;
    drive(1, 1, 16'h0010);
    total_cnt++;
    if (exhausted_x !== 1'b0 || success_x !== 1'b1 || prefix_x !== 4'd4 || state_x !== exp_state)
      $display("FAIL exh_restart: got e%0b s%0b p%0d st%0d want e0 s1 p4 st%0d",
               exhausted_x, success_x, prefix_x, state_x, exp_state);
    else pass_cnt++;
    // newblock landing on the wrap cycle: restart wins and the suffix reloads to 1
    drive(1, 1, 16'h0000);
    for (int i = 1; i <= 14; i++) drive(1, 0, 16'h0000);
    drive(1, 1, 16'h0000);
    total_cnt++;
    if (exhausted_x !== 1'b0 || state_x !== 2'd1)
      $display("FAIL exh_nb_wins: got e%0b st%0d want e0 st1", exhausted_x, state_x);
    else pass_cnt++;
    for (int i = 1; i <= 14; i++) drive(1, 0, 16'h0000);
    total_cnt++;
    if (exhausted_x !== 1'b0) $display("FAIL exh_reload_early: got %0b want 0", exhausted_x); else pass_cnt++;
    drive(1, 0, 16'h0000);
    total_cnt++;
    if (exhausted_x !== 1'b1) $display("FAIL exh_reload_wrap: got %0b want 1", exhausted_x); else pass_cnt++;
  endtask

  task automatic test_stop_on_first();
    int exp_pulses;
    logic [7:0] exp_drop;
`ifdef NONCE_ENCODER_STOP_ON_FIRST_EN
    exp_pulses = 1; exp_drop = 8'd1;
`else
    exp_pulses = 2; exp_drop = 8'd0;
`endif
    pulses = 0;
    drive(1, 1, 16'h0000);
    if (success_o === 1'b1) pulses++;
    for (int s = 1; s <= 9; s++) begin
      if (s == 2) drive(1, 0, 16'h0100);
      else if (s == 7) drive(1, 0, 16'h0200);
      else drive(1, 0, 16'h0000);
      if (success_o === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses != exp_pulses) $display("FAIL stop_pulses: got %0d want %0d", pulses, exp_pulses); else pass_cnt++;
    total_cnt++;
    if (dropped_o !== exp_drop) $display("FAIL stop_dropped: got %0d want %0d", dropped_o, exp_drop); else pass_cnt++;
  endtask

  task automatic test_reset_mid_block();
    drive(1, 1, 16'h0002);
    rst = 1'b0;
    drive(1, 0, 16'hFFFF);
    total_cnt++;
    if ({success_o, multi_hit_o, dropped_o, dbg_state} !== 12'd0)
      $display("FAIL mid_reset: got s%0b m%0b d%0d st%0d want all 0", success_o, multi_hit_o, dropped_o, dbg_state);
    else pass_cnt++;
    rst = 1'b1;
    drive(1, 0, 16'h0001);
    total_cnt++;
    if (success_o !== 1'b0 || valid_o !== 1'b1 || dbg_state !== 2'd0)
      $display("FAIL idle_ignore: got s%0b v%0b st%0d want s0 v1 st0", success_o, valid_o, dbg_state);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_gap();
    test_multi_hit();
    test_back_to_back();
    test_exhaustion();
    test_stop_on_first();
    test_reset_mid_block();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
